// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial datapath: engine state encoding,
// shift-direction encoding and the bit-counter width helper.
package serial_pkg;

   // Engine sequencing: wait for a word, shift it, report completion.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Shift direction encoding used by the MSB_FIRST parameter.
   localparam bit LSB_FIRST_C = 1'b0;
   localparam bit MSB_FIRST_C = 1'b1;

   // Counter wide enough to hold 0..width inclusive.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/shift_lane.sv
// WIDTH-bit shift register with clear, parallel load and enabled shift.
// Shifts toward the output end (bit 0 for LSB-first, bit WIDTH-1 for
// MSB-first) and takes ser_i in at the opposite end. Exposes the bit at the
// output end and the value the register would take on a shift.
module shift_lane
   import serial_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = LSB_FIRST_C
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             shift_i,
   input  logic             ser_i,
   output logic             head_o,
   output logic [WIDTH-1:0] next_o
);

   logic [WIDTH-1:0] data_q;

   generate
      if (MSB_FIRST == MSB_FIRST_C) begin : g_msb
         assign head_o = data_q[WIDTH-1];
         assign next_o = {data_q[WIDTH-2:0], ser_i};
      end else begin : g_lsb
         assign head_o = data_q[0];
         assign next_o = {ser_i, data_q[WIDTH-1:1]};
      end
   endgenerate

   // Register update: clear beats load, load beats shift, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (clr_i) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= load_data_i;
      end else if (shift_i) begin
         data_q <= next_o;
      end
   end

endmodule

// File: rtl/serial_shift_engine.sv
// Parallel-to-serial transmitter with a simultaneous serial-to-parallel
// capture path. A word accepted in IDLE is shifted out one bit per enabled
// cycle while the returning bit stream is collected; the captured word is
// published on par_out together with a one-cycle done pulse.
module serial_shift_engine
   import serial_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = LSB_FIRST_C,
   parameter int CNT_W     = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   input  logic             flush,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_in,
   output logic             done,
   output logic [WIDTH-1:0] par_out
);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] par_out_q;
   logic [WIDTH-1:0] cap_d;
   logic [WIDTH-1:0] tx_next_unused;
   logic             cap_head_unused;
   logic             accept;
   logic             step;

   // flush overrides both a pending load and a pending shift.
   assign accept = (state_q == IDLE)  && load_valid && !flush;
   assign step   = (state_q == SHIFT) && shift_en   && !flush;

   // Transmit lane: zero fill behind the outgoing bits.
   shift_lane #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_tx_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (flush),
      .load_i      (accept),
      .load_data_i (load_data),
      .shift_i     (step),
      .ser_i       (1'b0),
      .head_o      (ser_out),
      .next_o      (tx_next_unused)
   );

   // Capture lane: cleared on accept, filled from ser_in in transmit order so
   // the k-th captured bit lands in the k-th transmitted bit position.
   shift_lane #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_cap_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (1'b0),
      .load_i      (accept),
      .load_data_i ({WIDTH{1'b0}}),
      .shift_i     (step),
      .ser_i       (ser_in),
      .head_o      (cap_head_unused),
      .next_o      (cap_d)
   );

   // Sequencer, bit counter and captured-word register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         par_out_q <= '0;
      end else if (flush) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_valid) begin
                  state_q <= SHIFT;
                  cnt_q   <= '0;
               end
            end
            SHIFT: begin
               if (shift_en) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(WIDTH - 1)) begin
                     // Last bit: publish the capture including this ser_in.
                     par_out_q <= cap_d;
                     state_q   <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign load_ready = (state_q == IDLE);
   assign ser_valid  = (state_q == SHIFT);
   assign done       = (state_q == DONE);
   assign par_out    = par_out_q;

endmodule
